// File: rtl/ifid_fetch_stage_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction-memory port and IF/ID outputs.
// Optional perf counter outputs exist only when IFID_PERF_CNT_EN is defined.
interface ifid_fetch_stage_if;
   logic        stall_IF_ID;
   logic        flush_IF_ID;
   logic        Redirect_ID;
   logic [31:0] RedirectTarget_ID;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] PC_F;
   logic [31:0] Instr_D;
   logic [31:0] PCPlus4_D;
   logic        Valid_D;
`ifdef IFID_PERF_CNT_EN
   logic [31:0] fetch_count;
   logic [31:0] stall_count;
   logic [31:0] bubble_count;
`endif

   // fetch stage side: owns the PC and drives the instruction-memory address
   modport master (
      input  stall_IF_ID, flush_IF_ID, Redirect_ID, RedirectTarget_ID, imem_rdata,
      output imem_addr, PC_F, Instr_D, PCPlus4_D, Valid_D
`ifdef IFID_PERF_CNT_EN
      , output fetch_count, stall_count, bubble_count
`endif
   );

   // hazard unit / decode / memory side
   modport slave (
      output stall_IF_ID, flush_IF_ID, Redirect_ID, RedirectTarget_ID, imem_rdata,
      input  imem_addr, PC_F, Instr_D, PCPlus4_D, Valid_D
`ifdef IFID_PERF_CNT_EN
      , input fetch_count, stall_count, bubble_count
`endif
   );
endinterface

// File: rtl/ifid_fetch_stage.sv
// MIPS instruction-fetch stage with the IF/ID pipeline register.
// Define IFID_PERF_CNT_EN to add fetch/stall/bubble performance counters.
module ifid_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input logic                clk,
   input logic                reset,
   ifid_fetch_stage_if.master bus
);

   logic [31:0] pc_r;
   logic [31:0] pc_next_s;
   logic [31:0] pc_plus4_s;
   logic [31:0] redirect_pc_s;
   logic [31:0] instr_r;
   logic [31:0] pcplus4_r;
   logic        valid_r;
   logic        bubble_s;
   logic        load_s;
   logic [1:0]  target_unused_s;

   // Modular add: FFFF_FFFC + 4 wraps to 0 silently.
   assign pc_plus4_s      = pc_r + 32'd4;
   assign redirect_pc_s   = {bus.RedirectTarget_ID[31:2], 2'b00};
   assign target_unused_s = bus.RedirectTarget_ID[1:0];

   // Next-PC select: redirect beats stall so a stalled jump still steers fetch.
   always_comb begin
      pc_next_s = pc_plus4_s;
      if (bus.Redirect_ID) begin
         pc_next_s = redirect_pc_s;
      end else if (bus.stall_IF_ID) begin
         pc_next_s = pc_r;
      end else begin
         pc_next_s = pc_plus4_s;
      end
   end

   // IF/ID control: a bubble beats a stall, a stall blocks a normal load.
   always_comb begin
      bubble_s = 1'b0;
      load_s   = 1'b0;
      if (bus.Redirect_ID || bus.flush_IF_ID) begin
         bubble_s = 1'b1;
      end else if (bus.stall_IF_ID) begin
         load_s = 1'b0;
      end else begin
         load_s = 1'b1;
      end
   end

   // Program counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_r <= RESET_PC;
      end else begin
         pc_r <= pc_next_s;
      end
   end

   // IF/ID pipeline register.
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_r   <= 32'h0000_0000;
         pcplus4_r <= 32'h0000_0000;
         valid_r   <= 1'b0;
      end else if (bubble_s) begin
         instr_r   <= NOP_INSTR;
         pcplus4_r <= 32'h0000_0000;
         valid_r   <= 1'b0;
      end else if (load_s) begin
         instr_r   <= bus.imem_rdata;
         pcplus4_r <= pc_plus4_s;
         valid_r   <= 1'b1;
      end else begin
         instr_r   <= instr_r;
         pcplus4_r <= pcplus4_r;
         valid_r   <= valid_r;
      end
   end

   assign bus.imem_addr = pc_r;
   assign bus.PC_F      = pc_r;
   assign bus.Instr_D   = instr_r;
   assign bus.PCPlus4_D = pcplus4_r;
   assign bus.Valid_D   = valid_r;

`ifdef IFID_PERF_CNT_EN
   logic [31:0] fetch_cnt_r;
   logic [31:0] stall_cnt_r;
   logic [31:0] bubble_cnt_r;
   logic        stall_evt_s;

   assign stall_evt_s = bus.stall_IF_ID & ~bubble_s;

   // Event counters; each wraps at 2^32 and steps at most once per edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_cnt_r  <= 32'h0000_0000;
         stall_cnt_r  <= 32'h0000_0000;
         bubble_cnt_r <= 32'h0000_0000;
      end else begin
         fetch_cnt_r  <= fetch_cnt_r  + {31'd0, load_s};
         stall_cnt_r  <= stall_cnt_r  + {31'd0, stall_evt_s};
         bubble_cnt_r <= bubble_cnt_r + {31'd0, bubble_s};
      end
   end

   assign bus.fetch_count  = fetch_cnt_r;
   assign bus.stall_count  = stall_cnt_r;
   assign bus.bubble_count = bubble_cnt_r;
`endif

endmodule

// File: tb/tb_ifid_fetch_stage.sv
// Scoreboard bench for ifid_fetch_stage: directed vectors push expected IF state,
// per-instance monitors pop and compare one edge later.
module tb_ifid_fetch_stage;

   localparam logic [31:0] NOP_A   = 32'h0000_0820;
   localparam logic [31:0] RESET_B = 32'hFFFF_FFF8;

   typedef struct {
      logic        rst;
      logic        stall;
      logic        flush;
      logic        redir;
      logic [31:0] tgt;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic [31:0] fc;
      logic [31:0] sc;
      logic [31:0] bc;
   } vec_t;

   logic clk;
   logic reset_a;
   logic reset_b;
   int   checks;
   int   failures;
   int   row_a;
   int   row_b;

   vec_t rows_a[$];
   vec_t rows_b[$];
   vec_t exp_a[$];
   vec_t exp_b[$];
   vec_t e_a;
   vec_t e_b;

   ifid_fetch_stage_if bus_a ();
   ifid_fetch_stage_if bus_b ();

   ifid_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP_A)) dut_a (
      .clk(clk), .reset(reset_a), .bus(bus_a)
   );

   ifid_fetch_stage #(.RESET_PC(RESET_B)) dut_b (
      .clk(clk), .reset(reset_b), .bus(bus_b)
   );

   assign bus_a.imem_rdata = 32'h2000_0000 | bus_a.imem_addr;
   assign bus_b.imem_rdata = 32'h2000_0000 | bus_b.imem_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] im(input logic [31:0] a);
      return 32'h2000_0000 | a;
   endfunction

   function automatic vec_t mk(input logic rst, input logic stall, input logic flush,
                               input logic redir, input logic [31:0] tgt,
                               input logic [31:0] pc, input logic [31:0] instr,
                               input logic [31:0] pc4, input logic valid,
                               input logic [31:0] fc, input logic [31:0] sc,
                               input logic [31:0] bc);
      vec_t v;
      v.rst = rst; v.stall = stall; v.flush = flush; v.redir = redir; v.tgt = tgt;
      v.pc = pc; v.instr = instr; v.pc4 = pc4; v.valid = valid;
      v.fc = fc; v.sc = sc; v.bc = bc;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   // Monitor for instance A: compare after every edge with an outstanding expectation.
   always @(posedge clk) begin
      #1;
      if (exp_a.size() > 0) begin
         e_a = exp_a.pop_front();
         chk("A.PC_F", row_a, bus_a.PC_F, e_a.pc);
         chk("A.imem_addr", row_a, bus_a.imem_addr, e_a.pc);
         chk("A.Instr_D", row_a, bus_a.Instr_D, e_a.instr);
         chk("A.PCPlus4_D", row_a, bus_a.PCPlus4_D, e_a.pc4);
         chk("A.Valid_D", row_a, {31'd0, bus_a.Valid_D}, {31'd0, e_a.valid});
`ifdef IFID_PERF_CNT_EN
         chk("A.fetch_count", row_a, bus_a.fetch_count, e_a.fc);
         chk("A.stall_count", row_a, bus_a.stall_count, e_a.sc);
         chk("A.bubble_count", row_a, bus_a.bubble_count, e_a.bc);
`endif
         row_a++;
      end
   end

   // Monitor for instance B (wrapping reset PC).
   always @(posedge clk) begin
      #1;
      if (exp_b.size() > 0) begin
         e_b = exp_b.pop_front();
         chk("B.PC_F", row_b, bus_b.PC_F, e_b.pc);
         chk("B.Instr_D", row_b, bus_b.Instr_D, e_b.instr);
         chk("B.PCPlus4_D", row_b, bus_b.PCPlus4_D, e_b.pc4);
         chk("B.Valid_D", row_b, {31'd0, bus_b.Valid_D}, {31'd0, e_b.valid});
`ifdef IFID_PERF_CNT_EN
         chk("B.fetch_count", row_b, bus_b.fetch_count, e_b.fc);
`endif
         row_b++;
      end
   end

   initial begin
      checks = 0; failures = 0; row_a = 0; row_b = 0;
      reset_a = 1'b1; reset_b = 1'b1;
      bus_a.stall_IF_ID = 1'b0; bus_a.flush_IF_ID = 1'b0;
      bus_a.Redirect_ID = 1'b0; bus_a.RedirectTarget_ID = 32'h0000_0000;
      bus_b.stall_IF_ID = 1'b0; bus_b.flush_IF_ID = 1'b0;
      bus_b.Redirect_ID = 1'b0; bus_b.RedirectTarget_ID = 32'h0000_0000;

      //             rst stl fl  rd  target        pc            instr        pc4           v  fc  sc  bc
      rows_a.push_back(mk(1, 0, 0, 0, 32'h0,   32'h0,   32'h0,     32'h0,   0, 0,  0, 0));
      rows_a.push_back(mk(0, 0, 0, 0, 32'h0,   32'h4,   im(32'h0), 32'h4,   1, 1,  0, 0));
      rows_a.push_back(mk(0, 0, 0, 0, 32'h0,   32'h8,   im(32'h4), 32'h8,   1, 2,  0, 0));
      rows_a.push_back(mk(0, 0, 0, 0, 32'h0,   32'hC,   im(32'h8), 32'hC,   1, 3,  0, 0));
      rows_a.push_back(mk(0, 0, 0, 0, 32'h0,   32'h10,  im(32'hC), 32'h10,  1, 4,  0, 0));
      rows_a.push_back(mk(0, 1, 0, 0, 32'h0,   32'h10,  im(32'hC), 32'h10,  1, 4,  1, 0));
      rows_a.push_back(mk(0, 1, 0, 0, 32'h0,   32'h10,  im(32'hC), 32'h10,  1, 4,  2, 0));
      rows_a.push_back(mk(0, 1, 0, 0, 32'h0,   32'h10,  im(32'hC), 32'h10,  1, 4,  3, 0));
      rows_a.push_back(mk(0, 0, 0, 0, 32'h0,   32'h14,  im(32'h10), 32'h14, 1, 5,  3, 0));
      rows_a.push_back(mk(0, 0, 0, 0, 32'h0,   32'h18,  im(32'h14), 32'h18, 1, 6,  3, 0));
      rows_a.push_back(mk(0, 0, 0, 0, 32'h0,   32'h1C,  im(32'h18), 32'h1C, 1, 7,  3, 0));
      rows_a.push_back(mk(0, 0, 0, 0, 32'h0,   32'h20,  im(32'h1C), 32'h20, 1, 8,  3, 0));
      rows_a.push_back(mk(0, 0, 0, 1, 32'h103, 32'h100, NOP_A,      32'h0,  0, 8,  3, 1));
      rows_a.push_back(mk(0, 0, 0, 0, 32'h0,   32'h104, im(32'h100), 32'h104, 1, 9, 3, 1));
      rows_a.push_back(mk(0, 1, 0, 1, 32'h40,  32'h40,  NOP_A,      32'h0,  0, 9,  3, 2));
      rows_a.push_back(mk(0, 0, 0, 0, 32'h0,   32'h44,  im(32'h40), 32'h44, 1, 10, 3, 2));
      rows_a.push_back(mk(0, 1, 1, 0, 32'h0,   32'h44,  NOP_A,      32'h0,  0, 10, 3, 3));
      rows_a.push_back(mk(0, 0, 0, 0, 32'h0,   32'h48,  im(32'h44), 32'h48, 1, 11, 3, 3));
      rows_a.push_back(mk(0, 0, 1, 0, 32'h0,   32'h4C,  NOP_A,      32'h0,  0, 11, 3, 4));
      rows_a.push_back(mk(1, 1, 1, 1, 32'h200, 32'h0,   32'h0,      32'h0,  0, 0,  0, 0));
      rows_a.push_back(mk(0, 0, 0, 0, 32'h0,   32'h4,   im(32'h0),  32'h4,  1, 1,  0, 0));
      rows_a.push_back(mk(0, 0, 0, 0, 32'h0,   32'h8,   im(32'h4),  32'h8,  1, 2,  0, 0));
      rows_a.push_back(mk(0, 0, 0, 0, 32'h0,   32'hC,   im(32'h8),  32'hC,  1, 3,  0, 0));
      rows_a.push_back(mk(0, 0, 0, 0, 32'h0,   32'h10,  im(32'hC),  32'h10, 1, 4,  0, 0));
      rows_a.push_back(mk(0, 0, 0, 0, 32'h0,   32'h14,  im(32'h10), 32'h14, 1, 5,  0, 0));
      rows_a.push_back(mk(0, 1, 0, 0, 32'h0,   32'h14,  im(32'h10), 32'h14, 1, 5,  1, 0));
      rows_a.push_back(mk(0, 1, 0, 0, 32'h0,   32'h14,  im(32'h10), 32'h14, 1, 5,  2, 0));
      rows_a.push_back(mk(0, 0, 0, 1, 32'h80,  32'h80,  NOP_A,      32'h0,  0, 5,  2, 1));
      rows_a.push_back(mk(1, 1, 0, 1, 32'h300, 32'h0,   32'h0,      32'h0,  0, 0,  0, 0));
      rows_a.push_back(mk(0, 0, 0, 0, 32'h0,   32'h4,   im(32'h0),  32'h4,  1, 1,  0, 0));

      rows_b.push_back(mk(1, 0, 0, 0, 32'h0, RESET_B,      32'h0,            32'h0,        0, 0, 0, 0));
      rows_b.push_back(mk(0, 0, 0, 0, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFF8,   32'hFFFF_FFFC, 1, 1, 0, 0));
      rows_b.push_back(mk(0, 0, 0, 0, 32'h0, 32'h0000_0000, 32'hFFFF_FFFC,   32'h0000_0000, 1, 2, 0, 0));
      rows_b.push_back(mk(0, 0, 0, 0, 32'h0, 32'h0000_0004, 32'h2000_0000,   32'h0000_0004, 1, 3, 0, 0));

      fork
         begin
            foreach (rows_a[i]) begin
               @(negedge clk);
               reset_a                 = rows_a[i].rst;
               bus_a.stall_IF_ID       = rows_a[i].stall;
               bus_a.flush_IF_ID       = rows_a[i].flush;
               bus_a.Redirect_ID       = rows_a[i].redir;
               bus_a.RedirectTarget_ID = rows_a[i].tgt;
               exp_a.push_back(rows_a[i]);
            end
         end
         begin
            foreach (rows_b[j]) begin
               @(negedge clk);
               reset_b = rows_b[j].rst;
               exp_b.push_back(rows_b[j]);
            end
         end
      join

      for (int k = 0; k < 5 && (exp_a.size() + exp_b.size()) > 0; k++) begin
         @(negedge clk);
      end
      @(negedge clk);
      if ((exp_a.size() + exp_b.size()) != 0) begin
         checks++;
         failures++;
         $display("FAIL drain: got %0d pending expected 0", exp_a.size() + exp_b.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ifid_fetch_stage.md
# ifid_fetch_stage

Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline. Owns the program counter, drives the instruction-memory address, and latches the fetched instruction and PC+4 into the IF/ID register for decode. It is the direct consumer of the hazard unit's `stall_IF_ID` and of the decode stage's branch/jump redirect. It inserts bubbles on flush and redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, default 32'h0000_0000: encoding placed in `Instr_D` for a bubble (sll $0,$0,0).
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `stall_IF_ID` in 1: hold PC and IF/ID register.
- `flush_IF_ID` in 1: replace IF/ID contents with a bubble.
- `Redirect_ID` in 1: taken branch or jump resolved in ID.
- `RedirectTarget_ID` in 32: new PC for the redirect.
- `imem_addr` out 32: instruction-memory address; equals `PC_F`.
- `imem_rdata` in 32: instruction at `imem_addr`, combinational, same cycle.
- `PC_F` out 32: current fetch PC.
- `Instr_D` out 32: IF/ID instruction.
- `PCPlus4_D` out 32: IF/ID PC+4.
- `Valid_D` out 1: 1 = real instruction in IF/ID; 0 = bubble.

## Operation
- Next-PC priority, evaluated every cycle:
  - `reset`: load `RESET_PC`.
  - `Redirect_ID`: load {RedirectTarget_ID[31:2], 2'b00}.
  - `stall_IF_ID`: hold.
  - Otherwise: PC+4.
- IF/ID update priority, evaluated every cycle:
  - `reset`: Instr_D=0, PCPlus4_D=0, Valid_D=0.
  - `Redirect_ID` or `flush_IF_ID`: Instr_D=NOP_INSTR, PCPlus4_D=0, Valid_D=0.
  - `stall_IF_ID`: hold all three.
  - Otherwise: Instr_D=imem_rdata, PCPlus4_D=PC_F+4, Valid_D=1.
- Redirect beats stall. A jump held in ID by a stall still redirects, and the stall is not re-applied to the PC in that cycle.
- Flush beats stall on the IF/ID register. The PC still obeys the stall (it is held).
- PC+4 uses 32-bit modular arithmetic: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
- `RedirectTarget_ID[1:0]` are ignored (forced to 00). `PC_F[1:0]` is always 00 provided `RESET_PC[1:0]`=00.
- No internal state beyond the PC, the IF/ID register and the optional counters.

## Timing
- Reset values: PC_F=imem_addr=RESET_PC, Instr_D=0, PCPlus4_D=0, Valid_D=0, and all counters 0.
- Reset asserted mid-stream overrides stall, flush and redirect in that same edge.
- First fetch: the cycle after reset deasserts, imem_addr=RESET_PC. The edge that ends that cycle loads IF/ID with Valid_D=1.
- Fetch-to-decode latency: 1 cycle. The instruction at `PC_F` in cycle N appears on `Instr_D` in cycle N+1.
- Redirect asserted in cycle N: cycle N+1 has PC_F=target and a bubble in ID. The target instruction reaches ID in cycle N+2. Redirect penalty is 1 bubble.
- A stall of k cycles holds `PC_F` and `Instr_D` constant for exactly k edges, and `imem_addr` stays stable throughout.

## Configuration
- `IFID_PERF_CNT_EN` defined: adds the following outputs. Each is a 32-bit counter that wraps at 2^32, is cleared by `reset`, and increments by at most 1 per cycle.
  - `fetch_count`: edges where IF/ID loads with Valid_D=1.
  - `stall_count`: edges where `stall_IF_ID`=1 and no redirect, flush or reset.
  - `bubble_count`: edges where redirect or flush inserts a bubble.
- `IFID_PERF_CNT_EN` undefined: the three ports and all counter logic are absent, and functional behaviour is identical.

## Test plan
- Reset then free-run with imem_rdata=32'h2000_0000|addr: PC_F steps 0,4,8,C. Instr_D lags by one cycle, and Valid_D=1 from the 2nd edge on.
- Stall 3 cycles at PC=0x10: PC_F stays 0x10 and Instr_D stays the 0xC instruction for 3 edges, then resumes at 0x14.
- Redirect_ID=1, target=0x0000_0103 at PC=0x20: next PC_F=0x100, Instr_D=NOP_INSTR with Valid_D=0, then the 0x100 instruction with Valid_D=1.
- Simultaneous stall and redirect (target 0x40): PC_F=0x40 and a bubble in ID. Simultaneous stall and flush: PC held and a bubble in ID.
- RESET_PC=32'hFFFF_FFF8 free-run: PC_F sequence FFFF_FFF8, FFFF_FFFC, 0000_0000. PCPlus4_D reaches 0 for the FFFF_FFFC instruction.
- With IFID_PERF_CNT_EN: 5 normal fetches, 2 stalls, 1 redirect give fetch_count=5, stall_count=2, bubble_count=1. Reset asserted mid-run clears all counters and the pipeline on the same edge.
